cpu_hazard_unit: RTL and testbench

Parametrised interlock and bypass controller for the Falcon issue stage. It tracks destinations of in-flight fixed-latency operations in a FIXED_DEPTH-stage shadow pipeline, and tracks variable-latency (load/divide) destinations in an NREGS-bit scoreboard with NCOMP completion ports. Each cycle it decides whether the decoded instruction may issue and produces per-operand bypass selects. It sits between the decoder and the register-file/ALU boundary.

---
 rtl/cpu_hazard_unit_if.sv | 50 +++++
 rtl/cpu_hazard_unit.sv | 136 +++++++++++++
 tb/tb_cpu_hazard_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_hazard_unit_if.sv
// Issue-stage hazard interface: decoder request, completions and flush in;
// issue decision, bypass selects and status out.
interface cpu_hazard_unit_if #(
  parameter int NREGS       = 32,
  parameter int NCOMP       = 2,
  parameter int FIXED_DEPTH = 3
);
  localparam int RW = $clog2(NREGS);
  localparam int LW = $clog2(FIXED_DEPTH + 1);

  logic                   iss_valid;
  logic                   iss_ready;
  logic                   iss_fire;
  logic                   iss_use_a;
  logic                   iss_use_b;
  logic [RW-1:0]          iss_src_a;
  logic [RW-1:0]          iss_src_b;
  logic [RW-1:0]          iss_dest;
  logic [LW-1:0]          iss_lat;
  logic                   iss_res_busy;
  logic                   flush;
  logic                   flush_dest_valid;
  logic [RW-1:0]          flush_dest;
  logic [NCOMP-1:0]       cmp_valid;
  logic [NCOMP*RW-1:0]    cmp_dest;
  logic [FIXED_DEPTH-1:0] byp_a;
  logic [FIXED_DEPTH-1:0] byp_b;
  logic [NREGS-1:0]       busy_map;
  logic [2:0]             perf_code;

  modport master (
    output iss_valid, iss_use_a, iss_use_b,
    output iss_src_a, iss_src_b, iss_dest,
    output iss_lat, iss_res_busy,
    output flush, flush_dest_valid, flush_dest,
    output cmp_valid, cmp_dest,
    input  iss_ready, iss_fire, byp_a, byp_b,
    input  busy_map, perf_code
  );

  modport slave (
    input  iss_valid, iss_use_a, iss_use_b,
    input  iss_src_a, iss_src_b, iss_dest,
    input  iss_lat, iss_res_busy,
    input  flush, flush_dest_valid, flush_dest,
    input  cmp_valid, cmp_dest,
    output iss_ready, iss_fire, byp_a, byp_b,
    output busy_map, perf_code
  );
endinterface

// File: rtl/cpu_hazard_unit.sv
// Falcon issue interlock/bypass: fixed-latency shadow pipe plus scoreboard.
// HAZARD_CMP_FORWARD_EN lets same-cycle completions unblock issue.
module cpu_hazard_unit #(
  parameter int NREGS       = 32,
  parameter int NCOMP       = 2,
  parameter int FIXED_DEPTH = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  cpu_hazard_unit_if.slave hz
);
  localparam int RW = $clog2(NREGS);
  localparam int LW = $clog2(FIXED_DEPTH + 1);

  logic [FIXED_DEPTH-1:0] sv_q, sv_d;
  logic [RW-1:0]          sd_q [FIXED_DEPTH];
  logic [RW-1:0]          sd_d [FIXED_DEPTH];
  logic [LW-1:0]          sr_q [FIXED_DEPTH];
  logic [LW-1:0]          sr_d [FIXED_DEPTH];

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] cmp_mask, busy_eff;
  logic [2:0]       perf_q, perf_d;

  logic [RW-1:0]          src [2];
  logic [1:0]             use_w;
  logic [FIXED_DEPTH-1:0] byp [2];
  logic [1:0]             lat_hz, sb_hz;
  logic                   waw_hz, dep_hz;
  logic                   ready, fire, var_op;

  assign src[0] = hz.iss_src_a;
  assign src[1] = hz.iss_src_b;
  assign use_w  = {hz.iss_use_b, hz.iss_use_a};

  always_comb begin
    cmp_mask = '0;
    for (int i = 0; i < NCOMP; i++) begin
      if (hz.cmp_valid[i]) begin
        cmp_mask[hz.cmp_dest[i*RW +: RW]] = 1'b1;
      end
    end
  end

`ifdef HAZARD_CMP_FORWARD_EN
  assign busy_eff = busy_q & ~cmp_mask;
`else
  assign busy_eff = busy_q;
`endif

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      byp[o]    = '0;
      lat_hz[o] = 1'b0;
      sb_hz[o]  = 1'b0;
      if (use_w[o] && src[o] != '0) begin
        sb_hz[o] = busy_eff[src[o]];
        for (int k = FIXED_DEPTH - 1; k >= 0; k--) begin
          if (sv_q[k] && sd_q[k] == src[o]) begin
            byp[o]    = '0;
            byp[o][k] = (sr_q[k] == '0);
            lat_hz[o] = (sr_q[k] != '0);
          end
        end
      end
    end
  end

  assign var_op = (hz.iss_lat == '0);
  assign waw_hz = var_op && hz.iss_dest != '0
                  && busy_eff[hz.iss_dest];
  assign dep_hz = (|lat_hz) || (|sb_hz) || waw_hz;
  assign ready  = !(dep_hz || hz.iss_res_busy)
                  || hz.flush || !hz.iss_valid;
  assign fire   = hz.iss_valid && ready && !hz.flush;

  always_comb begin
    sv_d[0] = fire && !var_op && hz.iss_dest != '0;
    sd_d[0] = hz.iss_dest;
    sr_d[0] = hz.iss_lat - LW'(1);
    for (int k = 1; k < FIXED_DEPTH; k++) begin
      sv_d[k] = sv_q[k-1];
      sd_d[k] = sd_q[k-1];
      sr_d[k] = (sr_q[k-1] == '0) ? '0
                                  : sr_q[k-1] - LW'(1);
    end
  end

  // Issue set is applied last so it wins over a same-cycle clear.
  always_comb begin
    busy_d = busy_q & ~cmp_mask;
    if (hz.flush && hz.flush_dest_valid) begin
      busy_d[hz.flush_dest] = 1'b0;
    end
    if (fire && var_op && hz.iss_dest != '0) begin
      busy_d[hz.iss_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    if (hz.flush)                           perf_d = 3'd1;
    else if (hz.iss_valid && dep_hz)        perf_d = 3'd2;
    else if (hz.iss_valid && hz.iss_res_busy) perf_d = 3'd3;
    else if (!hz.iss_valid)                 perf_d = 3'd4;
    else                                    perf_d = 3'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sv_q   <= '0;
      busy_q <= '0;
      perf_q <= '0;
      for (int k = 0; k < FIXED_DEPTH; k++) begin
        sd_q[k] <= '0;
        sr_q[k] <= '0;
      end
    end else begin
      sv_q   <= sv_d;
      busy_q <= busy_d;
      perf_q <= perf_d;
      for (int k = 0; k < FIXED_DEPTH; k++) begin
        sd_q[k] <= sd_d[k];
        sr_q[k] <= sr_d[k];
      end
    end
  end

  assign hz.iss_ready = ready;
  assign hz.iss_fire  = fire;
  assign hz.byp_a     = byp[0];
  assign hz.byp_b     = byp[1];
  assign hz.busy_map  = busy_q;
  assign hz.perf_code = perf_q;
endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Scoreboard bench for cpu_hazard_unit: per-cycle expectations are queued
// with the stimulus and popped when the cycle's outputs are sampled.
module tb_cpu_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_hazard_unit_if hif ();

  cpu_hazard_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hif.slave)
  );

  typedef struct packed {
    logic       v, ua, ub;
    logic [4:0] sa, sb, d;
    logic [1:0] lat;
    logic       res, fl, fdv;
    logic [4:0] fd;
    logic [1:0] cv;
    logic [9:0] cd;
  } stim_t;

  typedef struct packed {
    logic       rdy, fire;
    logic [2:0] ba, bb;
  } obs_t;

  int checks = 0;
  int failures = 0;

  stim_t       sq [$];
  obs_t        eq [$];
  int          pq [$];
  logic [32:0] bq [$];

  localparam logic [32:0] NB = 33'h0;

  function automatic stim_t mk(bit v, bit ua, int sa, bit ub,
                               int sb, int d, int lat);
    stim_t s;
    s     = '0;
    s.v   = v;
    s.ua  = ua;
    s.sa  = 5'(sa);
    s.ub  = ub;
    s.sb  = 5'(sb);
    s.d   = 5'(d);
    s.lat = 2'(lat);
    return s;
  endfunction

  function automatic obs_t ob(bit r, bit f, int a, int b);
    return {r, f, 3'(a), 3'(b)};
  endfunction

  function automatic logic [32:0] bm(logic [31:0] v);
    return {1'b1, v};
  endfunction

  task automatic add(stim_t s, obs_t e, int p, logic [32:0] b);
    sq.push_back(s);
    eq.push_back(e);
    pq.push_back(p);
    bq.push_back(b);
  endtask

  task automatic drive(stim_t s);
    hif.iss_valid        = s.v;
    hif.iss_use_a        = s.ua;
    hif.iss_src_a        = s.sa;
    hif.iss_use_b        = s.ub;
    hif.iss_src_b        = s.sb;
    hif.iss_dest         = s.d;
    hif.iss_lat          = s.lat;
    hif.iss_res_busy     = s.res;
    hif.flush            = s.fl;
    hif.flush_dest_valid = s.fdv;
    hif.flush_dest       = s.fd;
    hif.cmp_valid        = s.cv;
    hif.cmp_dest         = s.cd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s; obs_t e, o; int p, n; logic [32:0] b;
    n = 0;
    add('0, ob(1, 0, 0, 0), 0, bm(0));
    add('0, ob(1, 0, 0, 0), 4, bm(0));
    while (sq.size() != 0) begin
      s = sq.pop_front(); drive(s); #1;
      e = eq.pop_front(); p = pq.pop_front(); b = bq.pop_front();
      o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset[%0d] rdy/fire/byp: got %b want %b", n, o, e);
      end
      if (p >= 0) begin
        checks++;
        if (hif.perf_code !== 3'(p)) begin
          failures++;
          $display("FAIL reset[%0d] perf: got %0d want %0d",
                   n, hif.perf_code, p);
        end
      end
      if (b[32]) begin
        checks++;
        if (hif.busy_map !== b[31:0]) begin
          failures++;
          $display("FAIL reset[%0d] busy: got %h want %h",
                   n, hif.busy_map, b[31:0]);
        end
      end
      n++; cyc();
    end
  endtask

  task automatic test_fixed_bypass();
    stim_t s; obs_t e, o; int p, n; logic [32:0] b;
    n = 0;
    add(mk(1, 0, 0, 0, 0, 5, 2), ob(1, 1, 0, 0), -1, NB);
    add(mk(1, 1, 5, 0, 0, 6, 1), ob(0, 0, 0, 0), 0, NB);
    add(mk(1, 1, 5, 0, 0, 6, 1), ob(1, 1, 3'b010, 0), 2, NB);
    add(mk(1, 0, 0, 0, 0, 12, 3), ob(1, 1, 0, 0), 0, NB);
    add(mk(1, 0, 0, 1, 12, 0, 1), ob(0, 0, 0, 0), 0, NB);
    add(mk(1, 0, 0, 1, 12, 0, 1), ob(0, 0, 0, 0), 2, NB);
    add(mk(1, 0, 0, 1, 12, 0, 1), ob(1, 1, 0, 3'b100), 2, NB);
    add(mk(1, 0, 0, 1, 12, 0, 1), ob(1, 1, 0, 0), 0, NB);
    add(mk(1, 0, 0, 0, 0, 10, 1), ob(1, 1, 0, 0), 0, NB);
    add(mk(1, 1, 10, 1, 10, 0, 1), ob(1, 1, 3'b001, 3'b001), 0, NB);
    add(mk(1, 0, 0, 0, 0, 11, 3), ob(1, 1, 0, 0), 0, NB);
    add(mk(1, 0, 0, 0, 0, 11, 1), ob(1, 1, 0, 0), 0, NB);
    add(mk(1, 1, 11, 0, 11, 0, 1), ob(1, 1, 3'b001, 0), 0, NB);
    for (int i = 0; i < 3; i++) add('0, ob(1, 0, 0, 0), -1, NB);
    while (sq.size() != 0) begin
      s = sq.pop_front(); drive(s); #1;
      e = eq.pop_front(); p = pq.pop_front(); b = bq.pop_front();
      o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL fixed[%0d] rdy/fire/byp: got %b want %b", n, o, e);
      end
      if (p >= 0) begin
        checks++;
        if (hif.perf_code !== 3'(p)) begin
          failures++;
          $display("FAIL fixed[%0d] perf: got %0d want %0d",
                   n, hif.perf_code, p);
        end
      end
      if (b[32]) begin
        checks++;
        if (hif.busy_map !== b[31:0]) begin
          failures++;
          $display("FAIL fixed[%0d] busy: got %h want %h",
                   n, hif.busy_map, b[31:0]);
        end
      end
      n++; cyc();
    end
  endtask

  task automatic test_var_latency();
    stim_t s, rd; obs_t e, o; int p, n; logic [32:0] b;
    n = 0;
    rd = mk(1, 1, 7, 0, 0, 0, 1);
    add(mk(1, 0, 0, 0, 0, 7, 0), ob(1, 1, 0, 0), -1, bm(0));
    add(rd, ob(0, 0, 0, 0), 0, bm(32'h80));
    add(rd, ob(0, 0, 0, 0), 2, bm(32'h80));
    add(rd, ob(0, 0, 0, 0), 2, NB);
    s = rd; s.cv = 2'b10; s.cd = {5'd7, 5'd3};
`ifdef HAZARD_CMP_FORWARD_EN
    add(s, ob(1, 1, 0, 0), 2, bm(32'h80));
    add('0, ob(1, 0, 0, 0), 0, bm(0));
`else
    add(s, ob(0, 0, 0, 0), 2, bm(32'h80));
    add(rd, ob(1, 1, 0, 0), 2, bm(0));
`endif
    add(mk(1, 0, 0, 0, 0, 13, 0), ob(1, 1, 0, 0), -1, NB);
    s = '0; s.cv = 2'b11; s.cd = {5'd13, 5'd13};
    add(s, ob(1, 0, 0, 0), -1, bm(32'h2000));
    add('0, ob(1, 0, 0, 0), -1, bm(0));
    s = mk(1, 0, 0, 0, 0, 14, 0); s.cv = 2'b01; s.cd = {5'd0, 5'd14};
    add(s, ob(1, 1, 0, 0), -1, bm(0));
    add('0, ob(1, 0, 0, 0), 0, bm(32'h4000));
    s = '0; s.cv = 2'b01; s.cd = {5'd0, 5'd14};
    add(s, ob(1, 0, 0, 0), 4, bm(32'h4000));
    add('0, ob(1, 0, 0, 0), -1, bm(0));
    while (sq.size() != 0) begin
      s = sq.pop_front(); drive(s); #1;
      e = eq.pop_front(); p = pq.pop_front(); b = bq.pop_front();
      o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL varlat[%0d] rdy/fire/byp: got %b want %b", n, o, e);
      end
      if (p >= 0) begin
        checks++;
        if (hif.perf_code !== 3'(p)) begin
          failures++;
          $display("FAIL varlat[%0d] perf: got %0d want %0d",
                   n, hif.perf_code, p);
        end
      end
      if (b[32]) begin
        checks++;
        if (hif.busy_map !== b[31:0]) begin
          failures++;
          $display("FAIL varlat[%0d] busy: got %h want %h",
                   n, hif.busy_map, b[31:0]);
        end
      end
      n++; cyc();
    end
  endtask

  task automatic test_waw_flush();
    stim_t s, ld; obs_t e, o; int p, n; logic [32:0] b;
    n = 0;
    ld = mk(1, 0, 0, 0, 0, 9, 0);
    add(ld, ob(1, 1, 0, 0), -1, bm(0));
    add(ld, ob(0, 0, 0, 0), 0, bm(32'h200));
    s = ld; s.fl = 1'b1; s.fdv = 1'b1; s.fd = 5'd9;
    add(s, ob(1, 0, 0, 0), 2, bm(32'h200));
    add('0, ob(1, 0, 0, 0), 1, bm(0));
    add(mk(1, 0, 0, 0, 0, 15, 0), ob(1, 1, 0, 0), 4, bm(0));
    s = '0; s.fl = 1'b1; s.fd = 5'd15;
    add(s, ob(1, 0, 0, 0), 0, bm(32'h8000));
    s = '0; s.cv = 2'b01; s.cd = {5'd0, 5'd15};
    add(s, ob(1, 0, 0, 0), 1, bm(32'h8000));
    add('0, ob(1, 0, 0, 0), 4, bm(0));
    while (sq.size() != 0) begin
      s = sq.pop_front(); drive(s); #1;
      e = eq.pop_front(); p = pq.pop_front(); b = bq.pop_front();
      o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL waw[%0d] rdy/fire/byp: got %b want %b", n, o, e);
      end
      if (p >= 0) begin
        checks++;
        if (hif.perf_code !== 3'(p)) begin
          failures++;
          $display("FAIL waw[%0d] perf: got %0d want %0d",
                   n, hif.perf_code, p);
        end
      end
      if (b[32]) begin
        checks++;
        if (hif.busy_map !== b[31:0]) begin
          failures++;
          $display("FAIL waw[%0d] busy: got %h want %h",
                   n, hif.busy_map, b[31:0]);
        end
      end
      n++; cyc();
    end
  endtask

  task automatic test_r0_resource();
    stim_t s; obs_t e, o; int p, n; logic [32:0] b;
    n = 0;
    add(mk(1, 0, 0, 0, 0, 0, 1), ob(1, 1, 0, 0), -1, NB);
    add(mk(1, 1, 0, 1, 0, 0, 1), ob(1, 1, 0, 0), 0, NB);
    s = mk(1, 0, 0, 0, 0, 3, 1); s.res = 1'b1;
    add(s, ob(0, 0, 0, 0), 0, NB);
    add('0, ob(1, 0, 0, 0), 3, NB);
    add('0, ob(1, 0, 0, 0), 4, bm(0));
    while (sq.size() != 0) begin
      s = sq.pop_front(); drive(s); #1;
      e = eq.pop_front(); p = pq.pop_front(); b = bq.pop_front();
      o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL r0res[%0d] rdy/fire/byp: got %b want %b", n, o, e);
      end
      if (p >= 0) begin
        checks++;
        if (hif.perf_code !== 3'(p)) begin
          failures++;
          $display("FAIL r0res[%0d] perf: got %0d want %0d",
                   n, hif.perf_code, p);
        end
      end
      if (b[32]) begin
        checks++;
        if (hif.busy_map !== b[31:0]) begin
          failures++;
          $display("FAIL r0res[%0d] busy: got %h want %h",
                   n, hif.busy_map, b[31:0]);
        end
      end
      n++; cyc();
    end
  endtask

  task automatic test_reset_mid();
    stim_t s; obs_t e, o; int p, n; logic [32:0] b;
    n = 0;
    add(mk(1, 0, 0, 0, 0, 8, 0), ob(1, 1, 0, 0), -1, bm(0));
    add(mk(1, 0, 0, 0, 0, 9, 0), ob(1, 1, 0, 0), -1, bm(32'h100));
    add(mk(1, 0, 0, 0, 0, 20, 3), ob(1, 1, 0, 0), -1, bm(32'h300));
    add(mk(1, 0, 0, 0, 0, 8, 3), ob(1, 1, 0, 0), -1, bm(32'h300));
    while (sq.size() != 0) begin
      s = sq.pop_front(); drive(s); #1;
      e = eq.pop_front(); p = pq.pop_front(); b = bq.pop_front();
      o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rstmid[%0d] rdy/fire/byp: got %b want %b", n, o, e);
      end
      if (b[32]) begin
        checks++;
        if (hif.busy_map !== b[31:0]) begin
          failures++;
          $display("FAIL rstmid[%0d] busy: got %h want %h",
                   n, hif.busy_map, b[31:0]);
        end
      end
      n++; cyc();
    end
    eq.push_back(ob(0, 0, 0, 0));
    bq.push_back(bm(0));
    pq.push_back(0);
    eq.push_back(ob(1, 1, 0, 0));
    drive(mk(1, 1, 8, 0, 0, 0, 1));
    #1;
    o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
    e = eq.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL rstmid stall: got %b want %b", o, e);
    end
    #1 rst = 1'b1;
    #1;
    b = bq.pop_front();
    p = pq.pop_front();
    checks++;
    if (hif.busy_map !== b[31:0]) begin
      failures++;
      $display("FAIL rstmid async busy: got %h want %h",
               hif.busy_map, b[31:0]);
    end
    checks++;
    if (hif.perf_code !== 3'(p)) begin
      failures++;
      $display("FAIL rstmid async perf: got %0d want %0d",
               hif.perf_code, p);
    end
    #1 rst = 1'b0;
    #1;
    o = {hif.iss_ready, hif.iss_fire, hif.byp_a, hif.byp_b};
    e = eq.pop_front();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL rstmid reader r8: got %b want %b", o, e);
    end
    cyc();
    drive('0);
  endtask

  initial begin
    drive('0);
    #12 rst = 1'b0;
    test_reset();
    test_fixed_bypass();
    test_var_latency();
    test_waw_flush();
    test_r0_resource();
    test_reset_mid();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
